stage3_execute: RTL and testbench
=================================

// Module: stage3_execute
// PURPOSE
//  Execute stage fed by the register-read stage. It consumes s1/s2 operands plus decoded controls.
//  It computes the ALU result and branch condition, then registers them into the EX/MEM pipeline register.
//  result_out doubles as the X_reg forwarding source for the register-read stage operand muxes.
//  A multi-cycle multiply stalls upstream via stall_out.
// PARAMETERS
//  DW    32  operand/result width
//  AW    8   data/jump address width
//  MUL_N 32  multiply iterations (one shift-add step per cycle); must equal DW
// PORTS
//  clk                     in   1   clock, rising edge
//  rst                     in   1   asynchronous active-high reset
//  valid_in                in   1   operands/controls below hold a real instruction
//  flush                   in   1   kill instruction in flight (taken jump downstream)
//  s1_in, s2_in            in   DW  operands from register-read stage
//  D_in                    in   4   destination register index
//  address_in              in   AW  memory / jump address
//  RegWrite_in,RegInsrc_in in   1   writeback controls, passed through
//  DataRead_in,DataWrite_in in  1   memory controls, passed through
//  JumpSrc_in              in   1   instruction is a conditional jump
//  ALU_control_in          in   2   00 add/sub, 01 and, 10 or, 11 mul (xor without MUL_EN)
//  comparator_control_in   in   2   00 EQ, 01 NE, 10 GT signed, 11 LT signed
//  isSub_in                in   1   with ALU 00: s1 - s2
//  stall_out               out  1   upstream must hold all inputs stable
//  valid_out               out  1   EX/MEM register holds a real instruction
//  result_out              out  DW  ALU result (also forwarding value)
//  store_data_out          out  DW  registered s1_in (STORE data)
//  D_out, address_out      out  4/AW registered pass-through
//  RegWrite_out,RegInsrc_out,DataRead_out,DataWrite_out out 1 registered, gated by valid_out
//  branch_taken            out  1   registered: JumpSrc & condition true & valid
//  branch_target           out  AW  registered address_in
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, iteration counter 0.
//  - Single-cycle ops: accepted when valid_in & ~stall_out; results visible after the next edge (latency 1).
//  - Arithmetic is DW-bit wraparound. No carry/overflow output. Comparator uses the same s1/s2 operands.
//  - When valid_out=0, RegWrite_out, DataRead_out, DataWrite_out and branch_taken are 0; data outputs hold.
//  - valid_in=0 or flush=1 (IDLE): next edge loads a bubble (valid_out=0). flush takes priority over valid_in.
//  - No downstream backpressure; EX/MEM updates every cycle unless the FSM is BUSY.
//  - FSM (MUL_EN only): IDLE / BUSY / DONE.
//    IDLE: valid_in & ALU==11 & ~flush -> latch operands + controls, cnt=0, go BUSY. stall_out=1 combinationally this cycle.
//    BUSY: one shift-add step per cycle; cnt++; stall_out=1; valid_out=0 (bubbles). cnt==MUL_N-1 -> DONE.
//    DONE: stall_out=0; inputs ignored (upstream advances at this edge); EX/MEM <= product[DW-1:0], valid_out=1; -> IDLE.
//  - Timing: acceptance edge E0; valid_out rises after edge E0+MUL_N+1. stall_out is high from presentation through edge E0+MUL_N.
//  - flush in BUSY or DONE: abort to IDLE, no result, valid_out=0.
//  - rst mid-multiply: immediate IDLE, partial product discarded.
// CONFIGURATION
//  - STAGE3_MUL_EN defined: ALU 11 = unsigned multiply (low DW bits), FSM as above.
//  - Not defined: ALU 11 = s1 ^ s2, single cycle; stall_out tied 0; no FSM or counter.
// TESTING
//  - Add/sub: s1=0xFFFFFFFF, s2=1, ALU=00, isSub=0 -> after 1 edge result_out=0, valid_out=1.
//    Same with isSub=1 -> 0xFFFFFFFE.
//  - Branch: JumpSrc=1, cmp=10, s1=-1, s2=1 -> branch_taken=0. cmp=11 -> branch_taken=1, branch_target=address_in.
//  - Bubble: valid_in=0, RegWrite_in=1 -> valid_out=0, RegWrite_out=0. Same instruction with flush=1 -> identical.
//  - MUL (STAGE3_MUL_EN): s1=7, s2=6, ALU=11 -> stall_out high for MUL_N+1 cycles, result_out=42 after edge E0+33.
//    0xFFFFFFFF*2 -> 0xFFFFFFFE.
//  - Abort: rst, or flush, at BUSY cnt=10 -> IDLE, stall_out=0, valid_out=0. Next ADD 3+4 -> 7 after 1 edge.
//  - No macro: ALU=11, s1=0xF0F0F0F0, s2=0xFFFF0000 -> result_out=0x0F0FF0F0 after 1 edge, stall_out never 1.

Source files
------------

// File: rtl/stage3_execute.sv
// Execute stage: ALU, branch comparator and EX/MEM pipeline register.
// Define STAGE3_MUL_EN to make ALU op 11 an iterative shift-add multiply (else op 11 is XOR).
module stage3_execute #(
    parameter int DW    = 32,
    parameter int AW    = 8,
    parameter int MUL_N = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    input  logic          flush,
    input  logic [DW-1:0] s1_in,
    input  logic [DW-1:0] s2_in,
    input  logic [3:0]    D_in,
    input  logic [AW-1:0] address_in,
    input  logic          RegWrite_in,
    input  logic          RegInsrc_in,
    input  logic          DataRead_in,
    input  logic          DataWrite_in,
    input  logic          JumpSrc_in,
    input  logic [1:0]    ALU_control_in,
    input  logic [1:0]    comparator_control_in,
    input  logic          isSub_in,
    output logic          stall_out,
    output logic          valid_out,
    output logic [DW-1:0] result_out,
    output logic [DW-1:0] store_data_out,
    output logic [3:0]    D_out,
    output logic [AW-1:0] address_out,
    output logic          RegWrite_out,
    output logic          RegInsrc_out,
    output logic          DataRead_out,
    output logic          DataWrite_out,
    output logic          branch_taken,
    output logic [AW-1:0] branch_target
);

    if (MUL_N != DW) begin : g_mul_n_check
        $error("stage3_execute: MUL_N must equal DW");
    end

    logic [DW-1:0] alu_res;
    logic          cond;
    logic [3:0]    in_ctl;

    assign in_ctl = {RegWrite_in, RegInsrc_in, DataRead_in, DataWrite_in};

    always_comb begin
        alu_res = '0;
        case (ALU_control_in)
            2'b00:   alu_res = isSub_in ? (s1_in - s2_in) : (s1_in + s2_in);
            2'b01:   alu_res = s1_in & s2_in;
            2'b10:   alu_res = s1_in | s2_in;
            default: alu_res = s1_in ^ s2_in;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        case (comparator_control_in)
            2'b00:   cond = (s1_in == s2_in);
            2'b01:   cond = (s1_in != s2_in);
            2'b10:   cond = ($signed(s1_in) > $signed(s2_in));
            default: cond = ($signed(s1_in) < $signed(s2_in));
        endcase
    end

    // Next EX/MEM contents; take=0 loads a bubble and leaves the data fields untouched.
    logic          take;
    logic [DW-1:0] n_result;
    logic [DW-1:0] n_store;
    logic [3:0]    n_d;
    logic [AW-1:0] n_addr;
    logic [3:0]    n_ctl;
    logic          n_br;

`ifdef STAGE3_MUL_EN
    // state  | meaning
    // S_IDLE | single-cycle ops flow through; ALU 11 starts a multiply
    // S_BUSY | one shift-add step per cycle, upstream stalled, bubbles issued
    // S_DONE | product written to EX/MEM, upstream released
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    localparam int CW = $clog2(MUL_N);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] mul_a;
    logic [DW-1:0] mul_b;
    logic [DW-1:0] acc;
    logic [DW-1:0] l_s1;
    logic [3:0]    l_d;
    logic [AW-1:0] l_addr;
    logic [3:0]    l_ctl;
    logic          l_br;
    logic          start;

    assign start     = (state == S_IDLE) & valid_in & ~flush & (ALU_control_in == 2'b11);
    assign stall_out = start | (state == S_BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
            acc    <= '0;
            l_s1   <= '0;
            l_d    <= '0;
            l_addr <= '0;
            l_ctl  <= '0;
            l_br   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_BUSY;
                        cnt    <= '0;
                        mul_a  <= s1_in;
                        mul_b  <= s2_in;
                        acc    <= '0;
                        l_s1   <= s1_in;
                        l_d    <= D_in;
                        l_addr <= address_in;
                        l_ctl  <= in_ctl;
                        l_br   <= JumpSrc_in & cond;
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        if (mul_b[0]) acc <= acc + mul_a;
                        mul_a <= mul_a << 1;
                        mul_b <= mul_b >> 1;
                        cnt   <= cnt + 1'b1;
                        if (cnt == CW'(MUL_N - 1)) state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        take     = 1'b0;
        n_result = alu_res;
        n_store  = s1_in;
        n_d      = D_in;
        n_addr   = address_in;
        n_ctl    = in_ctl;
        n_br     = JumpSrc_in & cond;
        case (state)
            S_IDLE: take = valid_in & ~flush & (ALU_control_in != 2'b11);
            S_DONE: begin
                take     = ~flush;
                n_result = acc;
                n_store  = l_s1;
                n_d      = l_d;
                n_addr   = l_addr;
                n_ctl    = l_ctl;
                n_br     = l_br;
            end
            default: take = 1'b0;
        endcase
    end
`else
    assign stall_out = 1'b0;

    always_comb begin
        take     = valid_in & ~flush;
        n_result = alu_res;
        n_store  = s1_in;
        n_d      = D_in;
        n_addr   = address_in;
        n_ctl    = in_ctl;
        n_br     = JumpSrc_in & cond;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out      <= 1'b0;
            result_out     <= '0;
            store_data_out <= '0;
            D_out          <= '0;
            address_out    <= '0;
            RegWrite_out   <= 1'b0;
            RegInsrc_out   <= 1'b0;
            DataRead_out   <= 1'b0;
            DataWrite_out  <= 1'b0;
            branch_taken   <= 1'b0;
            branch_target  <= '0;
        end else begin
            valid_out <= take;
            {RegWrite_out, RegInsrc_out, DataRead_out, DataWrite_out} <= take ? n_ctl : 4'b0000;
            branch_taken <= take & n_br;
            if (take) begin
                result_out     <= n_result;
                store_data_out <= n_store;
                D_out          <= n_d;
                address_out    <= n_addr;
                branch_target  <= n_addr;
            end
        end
    end

endmodule

// File: tb/tb_stage3_execute.sv
// Scoreboard bench for stage3_execute; multiply checks compile in when STAGE3_MUL_EN is defined.
module tb_stage3_execute;
    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_in = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] s1_in = '0;
    logic [DW-1:0] s2_in = '0;
    logic [3:0]    D_in = '0;
    logic [AW-1:0] address_in = '0;
    logic          RegWrite_in = 1'b0;
    logic          RegInsrc_in = 1'b0;
    logic          DataRead_in = 1'b0;
    logic          DataWrite_in = 1'b0;
    logic          JumpSrc_in = 1'b0;
    logic [1:0]    ALU_control_in = '0;
    logic [1:0]    comparator_control_in = '0;
    logic          isSub_in = 1'b0;
    logic          stall_out;
    logic          valid_out;
    logic [DW-1:0] result_out;
    logic [DW-1:0] store_data_out;
    logic [3:0]    D_out;
    logic [AW-1:0] address_out;
    logic          RegWrite_out;
    logic          RegInsrc_out;
    logic          DataRead_out;
    logic          DataWrite_out;
    logic          branch_taken;
    logic [AW-1:0] branch_target;

    always #5 clk = ~clk;

    stage3_execute #(.DW(DW), .AW(AW), .MUL_N(32)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush),
        .s1_in(s1_in), .s2_in(s2_in), .D_in(D_in), .address_in(address_in),
        .RegWrite_in(RegWrite_in), .RegInsrc_in(RegInsrc_in),
        .DataRead_in(DataRead_in), .DataWrite_in(DataWrite_in),
        .JumpSrc_in(JumpSrc_in), .ALU_control_in(ALU_control_in),
        .comparator_control_in(comparator_control_in), .isSub_in(isSub_in),
        .stall_out(stall_out), .valid_out(valid_out), .result_out(result_out),
        .store_data_out(store_data_out), .D_out(D_out), .address_out(address_out),
        .RegWrite_out(RegWrite_out), .RegInsrc_out(RegInsrc_out),
        .DataRead_out(DataRead_out), .DataWrite_out(DataWrite_out),
        .branch_taken(branch_taken), .branch_target(branch_target)
    );

    typedef struct {
        logic [31:0] res;
        logic [31:0] st;
        logic [3:0]  d;
        logic [7:0]  addr;
        logic [3:0]  ctl;
        logic        bt;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          stall_hi = 0;
    logic [31:0] last_res = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic f, input logic [1:0] alu, input logic sub,
                         input logic [31:0] a, input logic [31:0] b, input logic js,
                         input logic [1:0] cmp, input logic [3:0] d, input logic [7:0] addr,
                         input logic [3:0] ctl);
        @(negedge clk);
        valid_in = v;
        flush = f;
        ALU_control_in = alu;
        isSub_in = sub;
        s1_in = a;
        s2_in = b;
        JumpSrc_in = js;
        comparator_control_in = cmp;
        D_in = d;
        address_in = addr;
        {RegWrite_in, RegInsrc_in, DataRead_in, DataWrite_in} = ctl;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 4'h0, 8'h00, 4'b0000);
    endtask

    task automatic op(input logic [1:0] alu, input logic sub, input logic [31:0] a,
                      input logic [31:0] b, input logic js, input logic [1:0] cmp,
                      input logic [3:0] d, input logic [7:0] addr, input logic [3:0] ctl,
                      input logic [31:0] res, input logic bt);
        drive(1'b1, 1'b0, alu, sub, a, b, js, cmp, d, addr, ctl);
        sb.push_back('{res: res, st: a, d: d, addr: addr, ctl: ctl, bt: bt});
        last_res = res;
    endtask

    task automatic bubble(input logic v, input logic f, input string tag);
        drive(v, f, 2'b00, 1'b0, 32'd3, 32'd4, 1'b1, 2'b01, 4'h9, 8'h77, 4'b1011);
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, valid_out, 0);
        chk({tag, "_regwrite"}, RegWrite_out, 0);
        chk({tag, "_branch"}, branch_taken, 0);
        chk({tag, "_hold"}, result_out, last_res);
    endtask

`ifdef STAGE3_MUL_EN
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                           input logic [3:0] d, input logic [7:0] addr);
        int n_stall = 0;
        int lat = 0;
        drive(1'b1, 1'b0, 2'b11, 1'b0, a, b, 1'b0, 2'b00, d, addr, 4'b1000);
        #1;
        chk("mul_stall_present", stall_out, 1);
        sb.push_back('{res: res, st: a, d: d, addr: addr, ctl: 4'b1000, bt: 1'b0});
        last_res = res;
        for (int e = 0; e <= 60 && lat == 0; e++) begin
            @(posedge clk);
            #1;
            if (valid_out) lat = e;
            else if (stall_out) n_stall++;
        end
        chk("mul_stall_cycles", n_stall + 1, 33);
        chk("mul_latency", lat, 33);
        idle();
    endtask
`endif

    // Scoreboard monitor: pops on every valid EX/MEM word, checks gating on bubbles.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (stall_out) stall_hi++;
            if (!rst) begin
                if (valid_out) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_valid", valid_out, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("result", result_out, e.res);
                        chk("store_data", store_data_out, e.st);
                        chk("d_out", D_out, e.d);
                        chk("address", address_out, e.addr);
                        chk("target", branch_target, e.addr);
                        chk("ctl", {RegWrite_out, RegInsrc_out, DataRead_out, DataWrite_out}, e.ctl);
                        chk("branch_taken", branch_taken, e.bt);
                    end
                end else begin
                    chk("gated_ctl", {RegWrite_out, RegInsrc_out, DataRead_out, DataWrite_out,
                                      branch_taken}, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", valid_out, 0);
        chk("rst_result", result_out, 0);
        chk("rst_store", store_data_out, 0);
        chk("rst_d", D_out, 0);
        chk("rst_addr", address_out, 0);
        chk("rst_target", branch_target, 0);
        chk("rst_stall", stall_out, 0);
        chk("rst_ctl", {RegWrite_out, RegInsrc_out, DataRead_out, DataWrite_out, branch_taken}, 0);
        @(negedge clk);
        rst = 1'b0;

        //  alu    sub   s1            s2            js    cmp    d     addr   ctl      result        bt
        op(2'b00, 1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 2'b00, 4'h3, 8'h10, 4'b1000, 32'h00000000, 1'b0);
        op(2'b00, 1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 2'b00, 4'h4, 8'h11, 4'b1100, 32'hFFFFFFFE, 1'b0);
        op(2'b01, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 2'b00, 4'h5, 8'h12, 4'b0010, 32'hF000F000, 1'b0);
        op(2'b10, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 2'b00, 4'h6, 8'h13, 4'b0001, 32'hFFF0FFF0, 1'b0);
        op(2'b00, 1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b1, 2'b10, 4'h0, 8'hA5, 4'b0000, 32'h00000000, 1'b0);
        op(2'b00, 1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b1, 2'b11, 4'h0, 8'h5A, 4'b0000, 32'h00000000, 1'b1);
        op(2'b00, 1'b0, 32'h00000005, 32'h00000005, 1'b1, 2'b00, 4'h0, 8'h20, 4'b0000, 32'h0000000A, 1'b1);
        op(2'b00, 1'b1, 32'h00000005, 32'h00000005, 1'b1, 2'b01, 4'h0, 8'h21, 4'b0000, 32'h00000000, 1'b0);
        op(2'b00, 1'b0, 32'h00000005, 32'h00000006, 1'b0, 2'b01, 4'h1, 8'h22, 4'b1000, 32'h0000000B, 1'b0);
        op(2'b01, 1'b0, 32'h00000001, 32'hFFFFFFFF, 1'b1, 2'b10, 4'h2, 8'h23, 4'b0100, 32'h00000001, 1'b1);

        bubble(1'b0, 1'b0, "bubble_invalid");
        bubble(1'b1, 1'b1, "bubble_flush");

`ifdef STAGE3_MUL_EN
        run_mul(32'd7, 32'd6, 32'd42, 4'h8, 8'h40);
        run_mul(32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 4'h9, 8'h41);

        drive(1'b1, 1'b0, 2'b11, 1'b0, 32'd7, 32'd6, 1'b0, 2'b00, 4'hA, 8'h50, 4'b1000);
        repeat (11) @(posedge clk);
        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'd0, 32'd0, 1'b0, 2'b00, 4'h0, 8'h00, 4'b0000);
        @(posedge clk);
        #1;
        chk("flush_abort_stall", stall_out, 0);
        chk("flush_abort_valid", valid_out, 0);
        op(2'b00, 1'b0, 32'd3, 32'd4, 1'b0, 2'b00, 4'hB, 8'h51, 4'b1000, 32'd7, 1'b0);
        @(posedge clk);
        #1;
        chk("add_after_flush", result_out, 32'd7);
        idle();

        drive(1'b1, 1'b0, 2'b11, 1'b0, 32'd7, 32'd6, 1'b0, 2'b00, 4'hC, 8'h60, 4'b1000);
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        valid_in = 1'b0;
        #1;
        chk("rst_abort_stall", stall_out, 0);
        chk("rst_abort_valid", valid_out, 0);
        @(negedge clk);
        rst = 1'b0;
        op(2'b00, 1'b0, 32'd3, 32'd4, 1'b0, 2'b00, 4'hD, 8'h61, 4'b1000, 32'd7, 1'b0);
        @(posedge clk);
        #1;
        chk("add_after_rst", result_out, 32'd7);
        idle();
`else
        op(2'b11, 1'b0, 32'hF0F0F0F0, 32'hFFFF0000, 1'b0, 2'b00, 4'h7, 8'h30, 4'b1010, 32'h0F0FF0F0, 1'b0);
        op(2'b11, 1'b0, 32'hFFFFFFFF, 32'h00000002, 1'b0, 2'b00, 4'h8, 8'h31, 4'b1000, 32'hFFFFFFFD, 1'b0);
        idle();
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
`ifndef STAGE3_MUL_EN
        chk("stall_never", stall_hi, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
